btn_reset_gen: RTL and testbench

Front-end conditioner that sits directly upstream of `soc`. It synchronizes and debounces the raw board button `btn1` and derives a stretched, glitch-free active-low reset for the core. It also provides a clean button level and one-cycle press/release events for software-visible GPIO. Its output replaces the direct use of `btn1` as the core reset.

---
 rtl/btn_reset_gen.sv | 151 +++++++++++++++
 tb/tb_btn_reset_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_reset_gen.sv
// btn_reset_gen: button synchronizer/debouncer and core reset stretcher.
// Conditions the raw active-low board button btn1 into a clean level
// and press/release events. It also generates a stretched active-low
// reset for the downstream core.
// Optional feature macro: BTN_RESET_EN.
//  - Defined: a debounced button press holds the core in reset.
//  - Undefined: only the power-on hold drives core_resetn.
`timescale 1ns/1ps

module btn_reset_gen #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn1,
    output logic core_resetn,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

`ifdef BTN_RESET_EN
    localparam logic BUTTON_RESETS_CORE = 1'b1;
`else
    localparam logic BUTTON_RESETS_CORE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_HOLD         = 2'd0,
        ST_RUN          = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_e;

    logic              sync1_q, sync2_q;
    logic              btn_pressed;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_resetn_q, core_resetn_d;

    // Two-flop synchronizer; resets to "released" so no false press at power-on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn1;
            sync2_q <= sync1_q;
        end
    end

    // The button is active-low, so pressed is the inverted synchronized level.
    assign btn_pressed = ~sync2_q;

    // Debounce: count consecutive disagreeing samples.
    // Accept the new level on the DEBOUNCE_CYCLES-th sample.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (btn_pressed == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d  = '0;
            level_d   = btn_pressed;
            press_d   = btn_pressed;
            release_d = ~btn_pressed;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Debounce state and the one-cycle event pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Reset sequencer next-state logic.
    // A press takes priority over hold completion.
    // core_resetn is registered from the next state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        unique case (state_q)
            ST_HOLD: begin
                if (BUTTON_RESETS_CORE && press_q) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // A release seen here is ignored.
                if (BUTTON_RESETS_CORE && press_q) begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                // The hold count restarts from zero on re-entry to HOLD.
                if (release_q) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
        core_resetn_d = (state_d == ST_RUN);
    end

    // Reset sequencer state, hold counter and the registered core reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            core_resetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            core_resetn_q <= core_resetn_d;
        end
    end

    assign core_resetn = core_resetn_q;
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_btn_reset_gen.sv
// Testbench for btn_reset_gen.
// Uses an event-level reference model and directed literal checks.
// Adds randomized button and reset activity.
// Follows BTN_RESET_EN in the same way as the design.
`timescale 1ns/1ps

module tb_btn_reset_gen;

    localparam int DC  = 16;
    localparam int RHC = 8;
    localparam int INF = 32'h7fffffff;
`ifdef BTN_RESET_EN
    localparam logic EN = 1'b1;
`else
    localparam logic EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic btn1   = 1'b1;
    logic core_resetn, btn_level, btn_press, btn_release;
    logic core2, level2, press2, release2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btn_reset_gen #(.DEBOUNCE_CYCLES(DC), .RESET_HOLD_CYCLES(RHC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn1       (btn1),
        .core_resetn(core_resetn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    btn_reset_gen #(.DEBOUNCE_CYCLES(2), .RESET_HOLD_CYCLES(1)) dut_small (
        .clk        (clk),
        .resetn     (resetn),
        .btn1       (btn1),
        .core_resetn(core2),
        .btn_level  (level2),
        .btn_press  (press2),
        .btn_release(release2)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model:
    //  - btn1 reaches the debouncer two edges after it is sampled.
    //  - The level flips once the last DC pressed samples all disagree with it.
    //  - The core is released from edge rel_edge onward.
    logic m_level, m_press, m_release, m_core;
    int   n_edge, rel_edge;
    logic bq[$];
    logic shist[$];

    task automatic model_reset();
        bq.delete();
        bq.push_back(1'b1);
        bq.push_back(1'b1);
        shist.delete();
        for (int i = 0; i < DC; i++) shist.push_back(1'b0);
        m_level   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_core    = 1'b0;
        n_edge    = 0;
        rel_edge  = RHC;
    endtask

    task automatic model_edge();
        logic old, s;
        bit all_differ;
        n_edge++;
        old = bq.pop_front();
        bq.push_back(btn1);
        s = ~old;
        shist.push_back(s);
        if (shist.size() > DC) void'(shist.pop_front());
        m_press   = 1'b0;
        m_release = 1'b0;
        all_differ = 1'b1;
        foreach (shist[i]) if (shist[i] == m_level) all_differ = 1'b0;
        if (all_differ) begin
            m_level = ~m_level;
            if (m_level) m_press = 1'b1;
            else         m_release = 1'b1;
        end
        m_core = (n_edge >= rel_edge);
        if (EN) begin
            if (m_press)   rel_edge = INF;
            if (m_release) rel_edge = n_edge + RHC + 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_edge();
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("core_resetn", core_resetn, m_core);
            chk("btn_level", btn_level, m_level);
            chk("btn_press", btn_press, m_press);
            chk("btn_release", btn_release, m_release);
            chk("pulse_exclusive", btn_press & btn_release, 1'b0);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    int hold;

    initial begin
        resetn = 1'b0;
        btn1   = 1'b1;
        cyc(5);
        chk("reset_core", core_resetn, 1'b0);
        chk("reset_level", btn_level, 1'b0);
        chk("reset_press", btn_press, 1'b0);
        chk("reset_release", btn_release, 1'b0);

        // Power-on hold.
        resetn = 1'b1;
        cyc(1);
        chk("small_core_edge1", core2, 1'b1);
        chk("core_low_edge1", core_resetn, 1'b0);
        cyc(6);
        chk("core_low_edge7", core_resetn, 1'b0);
        cyc(1);
        chk("core_high_edge8", core_resetn, 1'b1);
        chk("level_idle", btn_level, 1'b0);

        // Bounce rejection.
        repeat (3) begin
            btn1 = 1'b0; cyc(5);
            btn1 = 1'b1; cyc(3);
        end
        cyc(20);
        chk("bounce_level", btn_level, 1'b0);
        chk("bounce_core", core_resetn, 1'b1);
        chk("small_settled_core", core2, 1'b1);

        // Clean press: first sampled at edge E.
        btn1 = 1'b0;
        cyc(1);                       // E
        cyc(2);                       // E+2
        chk("small_level_E2", level2, 1'b0);
        cyc(1);                       // E+3
        chk("small_level_E3", level2, 1'b1);
        chk("small_press_E3", press2, 1'b1);
        cyc(13);                      // E+16
        chk("level_E16", btn_level, 1'b0);
        cyc(1);                       // E+17
        chk("level_E17", btn_level, 1'b1);
        chk("press_E17", btn_press, 1'b1);
        cyc(1);                       // E+18
        chk("press_E18", btn_press, 1'b0);
        chk("core_E18", core_resetn, ~EN);
        cyc(22);                      // E+40
        btn1 = 1'b1;
        cyc(1);                       // F
        cyc(16);                      // F+16
        chk("level_F16", btn_level, 1'b1);
        chk("release_F16", btn_release, 1'b0);
        cyc(1);                       // F+17 = R
        chk("level_R", btn_level, 1'b0);
        chk("release_R", btn_release, 1'b1);
        cyc(8);                       // R+8
        chk("core_R8", core_resetn, ~EN);
        cyc(1);                       // R+9
        chk("core_R9", core_resetn, 1'b1);

        // Asynchronous reset while the button is held.
        btn1 = 1'b0;
        cyc(1);                       // E
        cyc(18);                      // E+18
        chk("held_core", core_resetn, ~EN);
        #2 resetn = 1'b0;
        #1;
        chk("async_core", core_resetn, 1'b0);
        chk("async_level", btn_level, 1'b0);
        chk("async_press", btn_press, 1'b0);
        chk("async_release", btn_release, 1'b0);
        chk("async_small_core", core2, 1'b0);
        btn1 = 1'b1;
        cyc(3);
        resetn = 1'b1;
        cyc(7);
        chk("repower_core_edge7", core_resetn, 1'b0);
        cyc(1);
        chk("repower_core_edge8", core_resetn, 1'b1);

        // Randomized button activity with occasional resets.
        repeat (60) begin
            btn1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) hold = $urandom_range(1, 8);
            else                           hold = $urandom_range(10, 45);
            cyc(hold);
            if ($urandom_range(0, 19) == 0) begin
                #2 resetn = 1'b0;
                cyc($urandom_range(1, 3));
                resetn = 1'b1;
            end
        end
        btn1 = 1'b1;
        cyc(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
